uart_cmd_assembler: RTL and testbench



---
 rtl/uart_cmd_assembler.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_cmd_assembler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// ---------------------------------------------------------------------------
// uart_cmd_assembler
//
// Turns the byte stream from the UART receiver into DAC commands:
//   0x2c + WORD_BYTES data bytes : write one word into the FIFO of channel c
//   0x3c                         : trigger the SPI sender(s)  (c=0xF -> all)
//   0x4c                         : flush the FIFO(s)          (c=0xF -> all)
// Every packet is answered with one ack/error byte through the UART
// transmitter handshake: 0xA0|c on success, 0xE1 unknown opcode, 0xE2 bad
// channel, 0xE3 FIFO full, 0xE4 inter-byte timeout.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   rx_dv, rx_byte    received byte strobe and data
//   fifo_full         per-DAC FIFO full flags
//   fifo_wr_en        one-hot one-cycle FIFO write strobe
//   fifo_wr_data      assembled word, held between writes
//   send_start        one-cycle trigger strobe toward the SPI senders
//   fifo_clear        one-cycle FIFO flush strobe
//   tx_busy           UART transmitter busy
//   tx_start, tx_data one-cycle transmit request and the ack/error byte
//   busy              high whenever the command FSM is not idle
//   err_pulse         one-cycle strobe on every error (incl. dropped bytes)
// ---------------------------------------------------------------------------
module uart_cmd_assembler #(
    parameter int DACN         = 2,
    parameter int WORD_BYTES   = 3,
    parameter int TIMEOUT_CLKS = 2600
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_dv,
    input  logic [7:0]              rx_byte,
    input  logic [DACN-1:0]         fifo_full,
    output logic [DACN-1:0]         fifo_wr_en,
    output logic [8*WORD_BYTES-1:0] fifo_wr_data,
    output logic [DACN-1:0]         send_start,
    output logic [DACN-1:0]         fifo_clear,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    output logic                    busy,
    output logic                    err_pulse
);

    localparam int WW    = 8 * WORD_BYTES;
    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CLKS);
    localparam logic [4:0]       DACN_L   = 5'(DACN);

    localparam logic [3:0] OP_WRITE = 4'h2;
    localparam logic [3:0] OP_TRIG  = 4'h3;
    localparam logic [3:0] OP_CLEAR = 4'h4;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_COMMIT, S_ACK} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [WW-1:0]     shift_q, shift_d;
    logic [3:0]        ch_q, ch_d;
    logic [7:0]        ack_q, ack_d;
    logic [WW-1:0]     wr_data_q, wr_data_d;
    logic [DACN-1:0]   wr_en_q, wr_en_d;
    logic [DACN-1:0]   send_q, send_d;
    logic [DACN-1:0]   clear_q, clear_d;
    logic              err_q, err_d;

    // Header decode, only meaningful while rx_dv is high in IDLE.
    logic [3:0]      hdr_op, hdr_ch;
    logic            hdr_ch_ok, hdr_ch_all;
    logic [DACN-1:0] hdr_mask, ch_mask;
    logic [WW-1:0]   word_next;

    assign hdr_op     = rx_byte[7:4];
    assign hdr_ch     = rx_byte[3:0];
    assign hdr_ch_ok  = {1'b0, hdr_ch} < DACN_L;
    assign hdr_ch_all = (hdr_ch == 4'hF);
    assign hdr_mask   = hdr_ch_all ? '1 : (DACN'(1) << hdr_ch);
    assign ch_mask    = DACN'(1) << ch_q;
    // MSB-first: earlier bytes move up as new bytes enter at the bottom.
    assign word_next  = (shift_q << 8) | WW'(rx_byte);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        shift_d   = shift_q;
        ch_d      = ch_q;
        ack_d     = ack_q;
        wr_data_d = wr_data_q;
        wr_en_d   = '0;
        send_d    = '0;
        clear_d   = '0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_dv) begin
                    state_d = S_ACK;
                    if (hdr_op == OP_WRITE) begin
                        if (hdr_ch_ok) begin
                            state_d = S_DATA;
                            ch_d    = hdr_ch;
                            cnt_d   = '0;
                            timer_d = '0;
                            shift_d = '0;
                        end else begin
                            ack_d = 8'hE2;
                            err_d = 1'b1;
                        end
                    end else if (hdr_op == OP_TRIG || hdr_op == OP_CLEAR) begin
                        if (hdr_ch_ok || hdr_ch_all) begin
                            if (hdr_op == OP_TRIG) send_d  = hdr_mask;
                            else                   clear_d = hdr_mask;
                            ack_d = 8'hA0 | {4'h0, hdr_ch};
                        end else begin
                            ack_d = 8'hE2;
                            err_d = 1'b1;
                        end
                    end else begin
                        ack_d = 8'hE1;
                        err_d = 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (rx_dv) begin
                    shift_d = word_next;
                    timer_d = '0;
                    if (cnt_q == LAST_CNT) begin
                        // The write strobe is registered here so it lands in
                        // the single COMMIT cycle, one clock after the byte.
                        state_d = S_COMMIT;
                        cnt_d   = '0;
                        if ((fifo_full & ch_mask) == '0) begin
                            wr_en_d   = ch_mask;
                            wr_data_d = word_next;
                            ack_d     = 8'hA0 | {4'h0, ch_q};
                        end else begin
                            ack_d = 8'hE3;
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (timer_q == TMR_MAX) begin
                    // Partial word is dropped so the next packet starts clean.
                    state_d = S_ACK;
                    cnt_d   = '0;
                    timer_d = '0;
                    shift_d = '0;
                    ack_d   = 8'hE4;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_COMMIT: begin
                err_d   = rx_dv;
                state_d = S_ACK;
            end

            S_ACK: begin
                err_d = rx_dv;
                if (!tx_busy) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value of the others, independent of order.
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            timer_q   <= '0;
            shift_q   <= '0;
            ch_q      <= '0;
            ack_q     <= '0;
            wr_data_q <= '0;
            wr_en_q   <= '0;
            send_q    <= '0;
            clear_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            shift_q   <= shift_d;
            ch_q      <= ch_d;
            ack_q     <= ack_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            send_q    <= send_d;
            clear_q   <= clear_d;
            err_q     <= err_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign send_start   = send_q;
    assign fifo_clear   = clear_q;
    assign err_pulse    = err_q;
    assign tx_data      = ack_q;
    assign busy         = (state_q != S_IDLE);
    // Decoded from state so the request can fire on the ACK entry cycle.
    assign tx_start     = (state_q == S_ACK) && !tx_busy;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Scoreboard bench for uart_cmd_assembler (DACN=2, WORD_BYTES=3).
module tb_uart_cmd_assembler;

    localparam int TMO = 2600;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic [1:0]  fifo_full;
    logic [1:0]  fifo_wr_en;
    logic [23:0] fifo_wr_data;
    logic [1:0]  send_start;
    logic [1:0]  fifo_clear;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        err_pulse;

    uart_cmd_assembler #(.DACN(2), .WORD_BYTES(3), .TIMEOUT_CLKS(TMO)) dut (
        .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .send_start(send_start),
        .fifo_clear(fifo_clear), .tx_busy(tx_busy), .tx_start(tx_start),
        .tx_data(tx_data), .busy(busy), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {K_WR, K_SS, K_CLR, K_TX} kind_t;
    typedef struct {
        kind_t       kind;
        logic [1:0]  mask;
        logic [23:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   err_cnt = 0;
    int   tx_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic void push(input kind_t k, input logic [1:0] m, input logic [23:0] d);
        exp_t e;
        e.kind = k; e.mask = m; e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic pop_cmp(input kind_t k, input logic [1:0] m, input logic [23:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", {30'd0, k}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", {30'd0, k}, {30'd0, e.kind});
            check("sb_mask", {30'd0, m}, {30'd0, e.mask});
            check("sb_data", {8'd0, d}, {8'd0, e.data});
        end
    endtask

    // Monitor: compares every strobe/transmit request against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (err_pulse) err_cnt++;
            if (|{fifo_wr_en, send_start, fifo_clear})
                check("strobe_overlap",
                      {29'd0, 3'(32'(|fifo_wr_en) + 32'(|send_start) + 32'(|fifo_clear))}, 32'd1);
            if (fifo_wr_en != 0) pop_cmp(K_WR,  fifo_wr_en, fifo_wr_data);
            if (send_start != 0) pop_cmp(K_SS,  send_start, 24'd0);
            if (fifo_clear != 0) pop_cmp(K_CLR, fifo_clear, 24'd0);
            if (tx_start) begin
                tx_cnt++;
                pop_cmp(K_TX, 2'b00, {16'd0, tx_data});
            end
        end
    end

    // Drive one byte for one cycle; returns #1 after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(posedge clk); #1;
        rx_dv   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_wr_en"},   {30'd0, fifo_wr_en}, 32'd0);
        check({name, "_wr_data"}, {8'd0, fifo_wr_data}, 32'd0);
        check({name, "_send"},    {30'd0, send_start}, 32'd0);
        check({name, "_clear"},   {30'd0, fifo_clear}, 32'd0);
        check({name, "_tx"},      {23'd0, tx_start, tx_data}, 32'd0);
        check({name, "_busy"},    {30'd0, busy, err_pulse}, 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, t0;
        reset = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
        fifo_full = 2'b00; tx_busy = 1'b0;
        cycles(3);
        check_outputs_zero("reset");
        reset = 1'b0;
        cycles(2);

        // Write 0x123456 to channel 1.
        push(K_WR, 2'b10, 24'h123456);
        push(K_TX, 2'b00, 24'h0000A1);
        send_byte(8'h21); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        check("wr_latency", {30'd0, fifo_wr_en}, 32'h2);
        cycles(1);
        check("wr_one_cycle", {30'd0, fifo_wr_en}, 32'h0);
        wait_idle(20, "wr_idle");

        // Trigger channel 0, then clear all.
        push(K_SS, 2'b01, 24'd0);
        push(K_TX, 2'b00, 24'h0000A0);
        send_byte(8'h30);
        check("trig_latency", {30'd0, send_start}, 32'h1);
        wait_idle(20, "trig_idle");
        push(K_CLR, 2'b11, 24'd0);
        push(K_TX, 2'b00, 24'h0000AF);
        send_byte(8'h4F);
        check("clr_latency", {30'd0, fifo_clear}, 32'h3);
        wait_idle(20, "clr_idle");

        // Write to a full FIFO.
        fifo_full = 2'b01;
        e0 = err_cnt;
        push(K_TX, 2'b00, 24'h0000E3);
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        check("full_no_write", {30'd0, fifo_wr_en}, 32'h0);
        wait_idle(20, "full_idle");
        check("full_err", 32'(err_cnt - e0), 32'd1);
        check("wr_data_hold", {8'd0, fifo_wr_data}, 32'h123456);
        fifo_full = 2'b00;

        // Bad channel then unknown opcode.
        e0 = err_cnt;
        push(K_TX, 2'b00, 24'h0000E2);
        send_byte(8'h25);
        wait_idle(20, "badch_idle");
        push(K_TX, 2'b00, 24'h0000E1);
        send_byte(8'h70);
        wait_idle(20, "badop_idle");
        check("hdr_err_cnt", 32'(err_cnt - e0), 32'd2);

        // Inter-byte timeout, then a clean packet.
        e0 = err_cnt;
        push(K_TX, 2'b00, 24'h0000E4);
        send_byte(8'h20); send_byte(8'h99);
        cycles(TMO - 20);
        check("tmo_not_early", {31'd0, busy}, 32'd1);
        wait_idle(100, "tmo_idle");
        check("tmo_err", 32'(err_cnt - e0), 32'd1);
        push(K_WR, 2'b01, 24'hAABBCC);
        push(K_TX, 2'b00, 24'h0000A0);
        send_byte(8'h20); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        wait_idle(20, "tmo_next_idle");

        // Transmitter busy during ACK, with a stray byte dropped meanwhile.
        tx_busy = 1'b1;
        e0 = err_cnt; t0 = tx_cnt;
        push(K_SS, 2'b10, 24'd0);
        push(K_TX, 2'b00, 24'h0000A1);
        send_byte(8'h31);
        cycles(5);
        send_byte(8'h21);
        check("stray_err", {31'd0, err_pulse}, 32'd1);
        cycles(44);
        check("busy_hold_state", {31'd0, busy}, 32'd1);
        check("busy_no_tx", 32'(tx_cnt - t0), 32'd0);
        check("busy_tx_data", {24'd0, tx_data}, 32'hA1);
        tx_busy = 1'b0;
        cycles(5);
        check("busy_one_tx", 32'(tx_cnt - t0), 32'd1);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("stray_err_cnt", 32'(err_cnt - e0), 32'd1);

        // Reset during DATA discards everything.
        send_byte(8'h20); send_byte(8'h11);
        reset = 1'b1;
        cycles(2);
        check_outputs_zero("mid_reset");
        reset = 1'b0;
        cycles(20);
        check("mid_reset_no_ack", 32'(exp_q.size()), 32'd0);
        push(K_WR, 2'b01, 24'hDEADBE);
        push(K_TX, 2'b00, 24'h0000A0);
        send_byte(8'h20); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        wait_idle(20, "post_reset_idle");

        cycles(5);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
